// File: rtl/general_purpose_register_1.sv
// 20-bit datapath register: load-enabled full/half writes, add/sub, logical
// shifts and clear, selected by a 10-bit control word.
module general_purpose_register_1 #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned HALF  = WIDTH / 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] i,
  input  logic [9:0]       j,
  output logic [WIDTH-1:0] o
);

  localparam int unsigned SHW = 5;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_LO   = 3'b001,
    OP_HI   = 3'b010,
    OP_ADD  = 3'b011,
    OP_SUB  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_CLR  = 3'b111
  } op_e;

  op_e              op_c;
  logic [SHW-1:0]   shamt_c;
  logic             shift_oob_c;
  logic [WIDTH-1:0] nxt_c;
  logic             unused_rsvd;

  assign op_c        = op_e'(j[2:0]);
  assign shamt_c     = j[7:3];
  assign shift_oob_c = (32'(shamt_c) >= WIDTH);
  assign unused_rsvd = ^j[9:8];

  // Next value, always computed from the pre-edge contents of o
  always_comb begin
    nxt_c = o;
    unique case (op_c)
      OP_LOAD: nxt_c = i;
      OP_LO:   nxt_c = {o[WIDTH-1:HALF], i[HALF-1:0]};
      OP_HI:   nxt_c = {i[WIDTH-1:HALF], o[HALF-1:0]};
      OP_ADD:  nxt_c = WIDTH'(o + i);
      OP_SUB:  nxt_c = WIDTH'(o - i);
      OP_SHL:  nxt_c = shift_oob_c ? '0 : (o << shamt_c);
      OP_SHR:  nxt_c = shift_oob_c ? '0 : (o >> shamt_c);
      OP_CLR:  nxt_c = '0;
      default: nxt_c = o;
    endcase
  end

  // State register; reset dominates load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o <= '0;
    end else if (load) begin
      o <= nxt_c;
    end
  end

endmodule

// File: tb/tb_general_purpose_register_1.sv
// Directed self-checking bench for general_purpose_register_1.
module tb_general_purpose_register_1;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [19:0] i;
  logic [9:0]  j;
  logic [19:0] o;

  int n_checks = 0;
  int n_errors = 0;

  general_purpose_register_1 dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .i     (i),
    .j     (j),
    .o     (o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  // One load=1 edge with the given op/shift/reserved fields, sampled 1ns after
  task automatic do_op(input logic [2:0] op, input logic [4:0] sh,
                       input logic [1:0] rsv, input logic [19:0] d);
    @(negedge clk);
    load = 1'b1;
    i    = d;
    j    = {rsv, sh, op};
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  logic [19:0] hold_pat [8];
  logic [19:0] r_a, r_b;

  initial begin
    hold_pat = '{20'h00005, 20'h00056, 20'h00027, 20'h000B8,
                 20'h00049, 20'h0005A, 20'h0006B, 20'h0007C};
    reset = 1'b0;
    load  = 1'b0;
    i     = '0;
    j     = '0;
    #12;
    check("reset_init", o, 20'h00000);
    @(negedge clk);
    reset = 1'b1;

    // Async reset mid-cycle, no clock edge needed
    do_op(3'b000, 5'd0, 2'b00, 20'h12345);
    check("preload", o, 20'h12345);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", o, 20'h00000);
    #1;
    reset = 1'b1;

    // Hold with load=0 while i changes
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      i = hold_pat[k];
      j = 10'h000;
      @(posedge clk);
      #1;
      check($sformatf("hold_%0d", k), o, 20'h00000);
    end

    // Full and half writes
    do_op(3'b000, 5'd0, 2'b00, 20'hABCDE); check("full_wr", o, 20'hABCDE);
    do_op(3'b001, 5'd0, 2'b00, 20'h00123); check("lo_wr",   o, 20'hABD23);
    do_op(3'b010, 5'd0, 2'b00, 20'h55400); check("hi_wr",   o, 20'h55523);

    // load=0 holds a nonzero value
    @(negedge clk); i = 20'h0F0F0; j = 10'h000;
    @(posedge clk); #1;
    check("hold_nz", o, 20'h55523);

    // Arithmetic wrap; shift field must not disturb add
    do_op(3'b000, 5'd0, 2'b00, 20'hFFFFF);
    do_op(3'b011, 5'd7, 2'b00, 20'h00002); check("add_wrap", o, 20'h00001);
    do_op(3'b100, 5'd0, 2'b00, 20'h00003); check("sub_wrap", o, 20'hFFFFE);

    // Shifts including out-of-range amount
    do_op(3'b000, 5'd0,  2'b00, 20'h00001);
    do_op(3'b101, 5'd19, 2'b00, 20'h00000); check("shl_19", o, 20'h80000);
    do_op(3'b110, 5'd4,  2'b00, 20'h00000); check("shr_4",  o, 20'h08000);
    do_op(3'b101, 5'd25, 2'b00, 20'h00000); check("shl_25", o, 20'h00000);
    do_op(3'b000, 5'd0,  2'b00, 20'h80000);
    do_op(3'b110, 5'd20, 2'b00, 20'h00000); check("shr_20", o, 20'h00000);

    // Clear and reserved bits
    do_op(3'b000, 5'd0, 2'b00, 20'h3C3C3); check("pre_clr", o, 20'h3C3C3);
    do_op(3'b111, 5'd0, 2'b11, 20'h12345); check("clear",   o, 20'h00000);
    do_op(3'b000, 5'd0, 2'b11, 20'h6A5C3); r_a = o;
    do_op(3'b111, 5'd0, 2'b00, 20'h00000);
    do_op(3'b000, 5'd0, 2'b00, 20'h6A5C3); r_b = o;
    check("rsv_11", r_a, 20'h6A5C3);
    check("rsv_00", r_b, 20'h6A5C3);

    // Reset dominates load
    @(negedge clk);
    reset = 1'b0;
    load  = 1'b1;
    i     = 20'hFFFFF;
    j     = 10'h000;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_vs_load_%0d", k), o, 20'h00000);
    end
    // Release mid-cycle: value only changes at the next edge
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_no_edge", o, 20'h00000);
    @(posedge clk);
    #1;
    check("rel_edge", o, 20'hFFFFF);
    load = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/general_purpose_register_1.md
Name:
general_purpose_register_1

Overview:
- 20-bit general-purpose register for the UrCPU datapath.
- Holds a word on output `o` and updates it on the rising clock edge when `load` is asserted.
- The update is selected by a 10-bit control word `j`:
  - full or half-word writes
  - add or subtract
  - logical shifts
  - clear
- Sits between the ALU/bus (source of `i`) and the operand/bus consumers of `o`.

Parameters:
- WIDTH, 20, register/data width. Fixed at 20 for this block; `j` encoding below assumes 20.
- HALF, 10, half-word width (WIDTH/2).

Ports:
- clk  input  1  rising-edge clock; the single clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- load  input  1  update enable, sampled on rising clk.
- i  input  20  data operand.
- j  input  10  control word: j[2:0] op, j[7:3] shift amount, j[9:8] reserved.
- o  output  20  registered contents; directly the state register, no combinational path from inputs.

Behaviour:
- Reset:
  - reset=0 immediately forces o=20'h00000, independent of clk.
  - o holds 0 for as long as reset=0; reset dominates load.
  - Reset deasserting mid-cycle takes effect at the next rising edge only.
- load=0 at a rising edge: o holds its value; i and j are ignored.
- load=1 at a rising edge performs op j[2:0] (one-cycle latency; new value visible after that edge):
  - 000: o <= i.
  - 001: o[9:0] <= i[9:0]; o[19:10] unchanged.
  - 010: o[19:10] <= i[19:10]; o[9:0] unchanged.
  - 011: o <= (o + i) mod 2^20; carry discarded.
  - 100: o <= (o - i) mod 2^20; borrow discarded (wraps).
  - 101: o <= o << j[7:3], zero fill; shift amount >= 20 yields 0.
  - 110: o <= o >> j[7:3], logical, zero fill; shift amount >= 20 yields 0.
  - 111: o <= 0.
- j[7:3] is ignored for ops other than 101/110.
- j[9:8] is reserved; ignored for all ops and must not affect the result.
- No X propagation from reserved bits. All ops are computed from the pre-edge value of o.
- Single register, no FSM; o changes only on a rising clk edge with load=1, or on reset assertion.

Test Plan:
- Reset/hold:
  - Assert reset=0 asynchronously mid-cycle with o=20'h12345 → o=0 immediately, no edge required.
  - Release reset; drive load=0 with i cycling through 20'h00005, 20'h00056, 20'h00027, 20'h000B8, 20'h00049, 20'h0005A, 20'h0006B, 20'h0007C over eight cycles → o stays 20'h00000 throughout.
- Full and half writes:
  - load=1, op 000, i=20'hABCDE → o=20'hABCDE after one edge.
  - Then op 001, i=20'h00123 → o=20'hABD23.
  - Then op 010, i=20'h55400 → o=20'h55523.
- Arithmetic wrap:
  - o=20'hFFFFF, op 011, i=20'h00002 → o=20'h00001.
  - Then op 100, i=20'h00003 → o=20'hFFFFE.
- Shifts:
  - o=20'h00001, op 101, j[7:3]=19 → o=20'h80000.
  - Then op 110, j[7:3]=4 → o=20'h08000.
  - Then op 101, j[7:3]=25 → o=20'h00000.
- Clear and reserved bits:
  - o=20'h3C3C3, op 111 with j[9:8]=2'b11 → o=0.
  - Repeat op 000 with j[9:8]=2'b11 vs 2'b00 → identical results.
- Reset vs load:
  - Hold reset=0 with load=1, op 000, i=20'hFFFFF across several edges → o remains 0.
